// File: rtl/sync_debounce_pkg.sv
// Shared defaults and helpers for the synchronizer/debounce input conditioner.
package sync_debounce_pkg;

  localparam int DEFAULT_NUM_CH          = 4;
  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

  // Counter width able to hold values up to DEBOUNCE_CYCLES.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sync_debounce_ch.sv
// Single-bit channel: flop synchronizer chain followed by a consecutive-mismatch
// debounce counter, a registered level and registered one-cycle edge strobes.
module sync_debounce_ch
  import sync_debounce_pkg::*;
#(
  parameter int   NUM_STAGES      = DEFAULT_SYNC_STAGES,
  parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic RESET_VAL_BIT   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  generate
    if (NUM_STAGES < 2) begin : g_bad_stages
      $error("sync_debounce_ch: NUM_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
      $error("sync_debounce_ch: DEBOUNCE_CYCLES must be at least 1");
    end
  endgenerate

  logic [NUM_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  level_q;
  logic                  rise_q;
  logic                  fall_q;
  logic                  s;
  logic                  accept;

  // Pure shift chain: nothing sits between the synchronizer flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {NUM_STAGES{RESET_VAL_BIT}};
    end else begin
      sync_q <= {sync_q[NUM_STAGES-2:0], async_in};
    end
  end

  assign s      = sync_q[NUM_STAGES-1];
  assign accept = (s != level_q) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= RESET_VAL_BIT;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= accept & s;
      fall_q <= accept & ~s;
      if (s == level_q) begin
        cnt_q <= '0;
      end else if (accept) begin
        level_q <= s;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/sync_debounce.sv
// Multi-channel input conditioner: one independent synchronize+debounce
// channel per asynchronous input bit.
module sync_debounce
  import sync_debounce_pkg::*;
#(
  parameter int                NUM_CH          = DEFAULT_NUM_CH,
  parameter int                NUM_STAGES      = DEFAULT_SYNC_STAGES,
  parameter int                DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic [NUM_CH-1:0] RESET_VAL       = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] async_in,
  output logic [NUM_CH-1:0] level_out,
  output logic [NUM_CH-1:0] rise_out,
  output logic [NUM_CH-1:0] fall_out
);

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      sync_debounce_ch #(
        .NUM_STAGES      (NUM_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VAL_BIT   (RESET_VAL[i])
      ) u_ch (
        .clk      (clk),
        .rst      (rst),
        .async_in (async_in[i]),
        .level    (level_out[i]),
        .rise     (rise_out[i]),
        .fall     (fall_out[i])
      );
    end
  endgenerate

endmodule
